// File: rtl/bcd_seg_display_seq.sv
// bcd_seg_display_seq: iterative double-dabble binary to multi-digit seven-segment driver.
// Revision 1.0 - initial release.
`default_nettype none

module bcd_seg_display_seq #(
  parameter int VALUE_W    = 20,
  parameter int NUM_DIGITS = 6,
  parameter bit BLANK_LZ   = 1'b1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [VALUE_W-1:0]      value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [8*NUM_DIGITS-1:0] segs
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam logic [8*NUM_DIGITS-1:0] UNLIT = ACTIVE_LOW ? {(8*NUM_DIGITS){1'b1}} : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t                  state;
  logic [BCD_W-1:0]        bcd;
  logic [BCD_W-1:0]        bcd_adj;
  logic [VALUE_W-1:0]      bin;
  logic [VALUE_W-1:0]      pend_value;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_valid;
  logic                    ovf_acc;
  logic [CNT_W-1:0]        cnt;
  logic [8*NUM_DIGITS-1:0] segs_next;
  logic                    lead_zero;
  logic [3:0]              nib;
  logic [7:0]              lit;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  assign busy = (state != S_IDLE) || pend_valid;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i+:4] >= 4'd5) bcd_adj[4*i+:4] = bcd[4*i+:4] + 4'd3;
    end
  end

  // Walk from the top digit down so lead_zero means "this and all higher digits are zero".
  always_comb begin
    segs_next = UNLIT;
    lead_zero = 1'b1;
    nib       = 4'd0;
    lit       = 8'h00;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib       = bcd[4*i+:4];
      lead_zero = lead_zero && (nib == 4'd0);
      if (ovf_acc)                             lit = 8'h40;
      else if (BLANK_LZ && (i != 0) && lead_zero) lit = 8'h00;
      else                                     lit = {1'b0, seg7(nib)};
      lit[7] = dp[i];
      segs_next[8*i+:8] = ACTIVE_LOW ? ~lit : lit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pend_valid <= 1'b0;
      pend_value <= '0;
      pend_dp    <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      segs       <= UNLIT;
      ovf_acc    <= 1'b0;
      bcd        <= '0;
      bin        <= '0;
      dp         <= '0;
      cnt        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load) begin
            bin     <= value;
            dp      <= dp_mask;
            bcd     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= CNT_W'(VALUE_W);
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {bcd, bin} <= {bcd_adj[BCD_W-2:0], bin, 1'b0};
          ovf_acc    <= ovf_acc | bcd_adj[BCD_W-1];
          cnt        <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= S_LATCH;
          if (load) begin
            pend_value <= value;
            pend_dp    <= dp_mask;
            pend_valid <= 1'b1;
          end
        end
        S_LATCH: begin
          segs     <= segs_next;
          overflow <= ovf_acc;
          done     <= 1'b1;
          bcd      <= '0;
          ovf_acc  <= 1'b0;
          cnt      <= CNT_W'(VALUE_W);
          // A pending entry goes first; a load arriving now queues behind it.
          if (pend_valid) begin
            bin        <= pend_value;
            dp         <= pend_dp;
            state      <= S_SHIFT;
            pend_valid <= load;
            if (load) begin
              pend_value <= value;
              pend_dp    <= dp_mask;
            end
          end else if (load) begin
            bin   <= value;
            dp    <= dp_mask;
            state <= S_SHIFT;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
